// File: rtl/escalonador_polinomio_if.sv
// Requester and evaluator bus of the polynomial scheduler. The slave modport is
// the scheduler side; the master modport is the environment (requesters + evaluator).
interface escalonador_polinomio_if;
   logic        sol0, sol1;
   logic [15:0] x0, a0, b0, c0;
   logic [15:0] x1, a1, b1, c1;
   logic        fim0, fim1;
   logic [15:0] res0, res1;
   logic        ovf0, ovf1;
   logic        ini_op;
   logic [15:0] xo, ao, bo, co;
   logic [15:0] res_in;
   logic        pronto_in;
   logic        ovf_in;
   logic        ocupado;
   logic        erro_timeout;

   modport slave (
      input  sol0, sol1, x0, a0, b0, c0, x1, a1, b1, c1,
      input  res_in, pronto_in, ovf_in,
      output fim0, fim1, res0, res1, ovf0, ovf1,
      output ini_op, xo, ao, bo, co, ocupado, erro_timeout
   );

   modport master (
      output sol0, sol1, x0, a0, b0, c0, x1, a1, b1, c1,
      output res_in, pronto_in, ovf_in,
      input  fim0, fim1, res0, res1, ovf0, ovf1,
      input  ini_op, xo, ao, bo, co, ocupado, erro_timeout
   );
endinterface

// File: rtl/escalonador_polinomio.sv
// Round-robin scheduler sharing one polynomial evaluator between two requesters.
// Optional ESPERA watchdog enabled by defining ESCALONADOR_TIMEOUT_EN.
module escalonador_polinomio #(
   parameter int TIMEOUT = 32
) (
   input logic                     ck,
   input logic                     rst,
   escalonador_polinomio_if.slave  bus
);

   typedef enum logic [1:0] {OCIOSO, DISPARA, ESPERA, ENTREGA} estado_t;

   estado_t     estado_reg, estado_next;
   logic        ultimo_reg, ultimo_next;
   logic [63:0] op_reg, op_next;
   logic        ini_reg, ini_next;
   logic        ocupado_reg, ocupado_next;
   logic        erro_reg, erro_next;
   logic        entrega_next;
   logic [15:0] res_ent_next;
   logic        ovf_ent_next;
   logic        gnt;
   logic        estouro;
   logic [1:0]  sol;
   logic [63:0] opnd [2];

   assign sol     = {bus.sol1, bus.sol0};
   assign opnd[0] = {bus.x0, bus.a0, bus.b0, bus.c0};
   assign opnd[1] = {bus.x1, bus.a1, bus.b1, bus.c1};

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("TIMEOUT must be at least 1");
   end

`ifdef ESCALONADOR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_reg, cnt_next;

   // Counter runs only while waiting; any other state rearms it.
   always_comb begin
      cnt_next = '0;
      if (estado_reg == ESPERA)
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge ck) begin
      if (rst)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign estouro = (estado_reg == ESPERA) && (cnt_reg == CW'(TIMEOUT - 1));
`else
   assign estouro = 1'b0;
`endif

   always_comb begin
      estado_next  = estado_reg;
      ultimo_next  = ultimo_reg;
      op_next      = op_reg;
      ini_next     = 1'b0;
      erro_next    = 1'b0;
      entrega_next = 1'b0;
      res_ent_next = '0;
      ovf_ent_next = 1'b0;
      gnt          = ultimo_reg;
      case (estado_reg)
         OCIOSO: begin
            if (sol != 2'b00) begin
               gnt         = (sol == 2'b11) ? ~ultimo_reg : sol[1];
               ultimo_next = gnt;
               op_next     = opnd[gnt];
               ini_next    = 1'b1;
               estado_next = DISPARA;
            end
         end
         DISPARA: estado_next = ESPERA;
         ESPERA: begin
            // A result arriving on the watchdog's last cycle still wins.
            if (bus.pronto_in) begin
               entrega_next = 1'b1;
               res_ent_next = bus.res_in;
               ovf_ent_next = bus.ovf_in;
               estado_next  = ENTREGA;
            end else if (estouro) begin
               entrega_next = 1'b1;
               res_ent_next = '0;
               ovf_ent_next = 1'b1;
               erro_next    = 1'b1;
               estado_next  = ENTREGA;
            end
         end
         ENTREGA: estado_next = OCIOSO;
         default: estado_next = OCIOSO;
      endcase
      ocupado_next = (estado_next != OCIOSO);
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         estado_reg  <= OCIOSO;
         ultimo_reg  <= 1'b1;
         op_reg      <= '0;
         ini_reg     <= 1'b0;
         ocupado_reg <= 1'b0;
         erro_reg    <= 1'b0;
      end else begin
         estado_reg  <= estado_next;
         ultimo_reg  <= ultimo_next;
         op_reg      <= op_next;
         ini_reg     <= ini_next;
         ocupado_reg <= ocupado_next;
         erro_reg    <= erro_next;
      end
   end

   // Per-requester delivery registers; only the owner of the operation updates.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_req
      logic        fim_reg;
      logic [15:0] res_reg;
      logic        ovf_reg;
      logic        dono;

      assign dono = entrega_next && (ultimo_reg == 1'(gi));

      always_ff @(posedge ck) begin
         if (rst) begin
            fim_reg <= 1'b0;
            res_reg <= '0;
            ovf_reg <= 1'b0;
         end else begin
            fim_reg <= dono;
            if (dono) begin
               res_reg <= res_ent_next;
               ovf_reg <= ovf_ent_next;
            end
         end
      end
   end

   assign bus.fim0         = g_req[0].fim_reg;
   assign bus.fim1         = g_req[1].fim_reg;
   assign bus.res0         = g_req[0].res_reg;
   assign bus.res1         = g_req[1].res_reg;
   assign bus.ovf0         = g_req[0].ovf_reg;
   assign bus.ovf1         = g_req[1].ovf_reg;
   assign bus.ini_op       = ini_reg;
   assign bus.xo           = op_reg[63:48];
   assign bus.ao           = op_reg[47:32];
   assign bus.bo           = op_reg[31:16];
   assign bus.co           = op_reg[15:0];
   assign bus.ocupado      = ocupado_reg;
   assign bus.erro_timeout = erro_reg;

endmodule

// File: tb/tb_escalonador_polinomio.sv
// Directed bench for escalonador_polinomio: table of single operations plus
// hand sequences for arbitration, ignored handshakes, reset abort and watchdog.
module tb_escalonador_polinomio;

   logic ck = 1'b0;
   logic rst = 1'b1;
   always #5 ck = ~ck;

   escalonador_polinomio_if bus ();

   escalonador_polinomio #(.TIMEOUT(8)) dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus)
   );

`ifdef ESCALONADOR_TIMEOUT_EN
   localparam int D33 = 8;
`else
   localparam int D33 = 10;
`endif

   typedef struct {
      int          r;
      logic [15:0] x, a, b, c;
      logic [15:0] res;
      logic        ovf;
      int          dly;
   } vec_t;

   vec_t tbl [4];
   int   n_run = 0;
   int   n_fail = 0;
   int   n_ini = 0, n_fim0 = 0, n_fim1 = 0;

   // Pulse counters sampled at the active edge, read by the stimulus only at negedges.
   always @(posedge ck) begin
      if (bus.ini_op) n_ini++;
      if (bus.fim0)   n_fim0++;
      if (bus.fim1)   n_fim1++;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_ops(input int r, input logic [63:0] v);
      if (r == 0) {bus.x0, bus.a0, bus.b0, bus.c0} = v;
      else        {bus.x1, bus.a1, bus.b1, bus.c1} = v;
   endtask

   task automatic set_sol(input int r, input logic v);
      if (r == 0) bus.sol0 = v;
      else        bus.sol1 = v;
   endtask

   task automatic wait_ini(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!ok) begin
            @(negedge ck);
            ok = bus.ini_op;
         end
      end
   endtask

   // Evaluator model: answer dly ESPERA cycles after the ini_op cycle.
   task automatic finish_op(input int dly, input logic [15:0] r, input logic ov,
                            output int g, output logic erro);
      repeat (dly) @(negedge ck);
      bus.pronto_in = 1'b1;
      bus.res_in    = r;
      bus.ovf_in    = ov;
      @(negedge ck);
      bus.pronto_in = 1'b0;
      bus.res_in    = 16'hDEAD;
      bus.ovf_in    = 1'b1;
      g    = bus.fim0 ? 0 : (bus.fim1 ? 1 : -1);
      erro = bus.erro_timeout;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_flags"}, {25'd0, bus.fim0, bus.fim1, bus.ovf0, bus.ovf1,
                            bus.ini_op, bus.ocupado, bus.erro_timeout}, 32'd0);
      chk({tag, "_res"}, {bus.res0, bus.res1}, 32'd0);
      chk({tag, "_xa"}, {bus.xo, bus.ao}, 32'd0);
      chk({tag, "_bc"}, {bus.bo, bus.co}, 32'd0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.sol0 = 1'b0;
      bus.sol1 = 1'b0;
      bus.pronto_in = 1'b0;
      repeat (2) @(negedge ck);
      rst = 1'b0;
   endtask

   initial begin
      vec_t        v;
      logic        ok, e;
      int          g, f0, f1, i0, cnt;
      logic [15:0] oth_res, s0, s1;
      logic        oth_ovf;

      tbl[0] = '{0, 16'h0017, 16'h0026, 16'h814D, 16'h9326, 16'h1234, 1'b0, D33};
      tbl[1] = '{1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hBEEF, 1'b1, 3};
      tbl[2] = '{0, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h7E57, 1'b1, 1};
      tbl[3] = '{1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0042, 1'b0, 5};

      bus.sol0 = 1'b0; bus.sol1 = 1'b0;
      set_ops(0, 64'h0); set_ops(1, 64'h0);
      bus.res_in = 16'h0; bus.pronto_in = 1'b0; bus.ovf_in = 1'b0;

      repeat (2) @(negedge ck);
      check_zero("reset");
      rst = 1'b0;
      @(negedge ck);

      // Single operations from the table.
      for (int k = 0; k < 4; k++) begin
         v  = tbl[k];
         f0 = n_fim0; f1 = n_fim1; i0 = n_ini;
         oth_res = (v.r == 0) ? bus.res1 : bus.res0;
         oth_ovf = (v.r == 0) ? bus.ovf1 : bus.ovf0;
         set_ops(v.r, {v.x, v.a, v.b, v.c});
         set_ops(1 - v.r, {v.c, v.b, v.a, v.x});
         set_sol(v.r, 1'b1);
         wait_ini(ok);
         chk("ini_seen", {31'd0, ok}, 32'd1);
         chk("op_xa", {bus.xo, bus.ao}, {v.x, v.a});
         chk("op_bc", {bus.bo, bus.co}, {v.b, v.c});
         set_ops(v.r, ~{v.x, v.a, v.b, v.c});
         finish_op(v.dly, v.res, v.ovf, g, e);
         set_sol(v.r, 1'b0);
         chk("grant", g, v.r);
         chk("res", (v.r == 0) ? bus.res0 : bus.res1, v.res);
         chk("ovf", (v.r == 0) ? bus.ovf0 : bus.ovf1, v.ovf);
         chk("erro", {31'd0, e}, 32'd0);
         chk("other_res", (v.r == 0) ? bus.res1 : bus.res0, oth_res);
         chk("other_ovf", (v.r == 0) ? bus.ovf1 : bus.ovf0, oth_ovf);
         chk("held_xa", {bus.xo, bus.ao}, {v.x, v.a});
         chk("held_bc", {bus.bo, bus.co}, {v.b, v.c});
         @(negedge ck);
         chk("idle_after", {29'd0, bus.ocupado, bus.fim0, bus.fim1}, 32'd0);
         chk("ini_count", n_ini - i0, 1);
         chk("own_fim_count", (v.r == 0) ? n_fim0 - f0 : n_fim1 - f1, 1);
         chk("other_fim_count", (v.r == 0) ? n_fim1 - f1 : n_fim0 - f0, 0);
         $display("[TB] op %0d req %0d ops %h %h %h %h dly %0d -> grant %0d res %h ovf %b",
                  k, v.r, v.x, v.a, v.b, v.c, v.dly, g, v.res, v.ovf);
      end

      // pronto_in asserted while idle and during DISPARA must be ignored.
      s0 = bus.res0; s1 = bus.res1; f0 = n_fim0; f1 = n_fim1;
      bus.pronto_in = 1'b1; bus.res_in = 16'hFFFF; bus.ovf_in = 1'b1;
      repeat (3) @(negedge ck);
      chk("ign_idle_ocupado", {31'd0, bus.ocupado}, 32'd0);
      set_ops(0, 64'h0102_0304_0506_0708);
      bus.sol0 = 1'b1;
      wait_ini(ok);
      chk("ign_ini_seen", {31'd0, ok}, 32'd1);
      @(negedge ck);
      bus.pronto_in = 1'b0; bus.res_in = 16'h0;
      chk("ign_no_fim", {30'd0, bus.fim0, bus.fim1}, 32'd0);
      chk("ign_waiting", {31'd0, bus.ocupado}, 32'd1);
      repeat (2) @(negedge ck);
      chk("ign_fim_count", (n_fim0 - f0) + (n_fim1 - f1), 0);
      chk("ign_res", {bus.res0, bus.res1}, {s0, s1});
      finish_op(2, 16'h0BEE, 1'b0, g, e);
      bus.sol0 = 1'b0;
      chk("ign_grant", g, 0);
      chk("ign_res0", bus.res0, 16'h0BEE);
      $display("[TB] ignore-handshake op -> grant %0d res0 %h", g, bus.res0);
      @(negedge ck);

      // Simultaneous requests right after reset: requester 0 first.
      reset_dut();
      i0 = n_ini;
      set_ops(0, 64'hAAAA_0001_0002_0003);
      set_ops(1, 64'h5555_0004_0005_0006);
      bus.sol0 = 1'b1; bus.sol1 = 1'b1;
      wait_ini(ok);
      chk("sim_xo0", bus.xo, 16'hAAAA);
      finish_op(2, 16'hAAAA, 1'b0, g, e);
      bus.sol0 = 1'b0;
      chk("sim_first", g, 0);
      $display("[TB] simultaneous op 1 -> grant %0d", g);
      wait_ini(ok);
      chk("sim_xo1", bus.xo, 16'h5555);
      finish_op(3, 16'h5555, 1'b1, g, e);
      bus.sol1 = 1'b0;
      chk("sim_second", g, 1);
      $display("[TB] simultaneous op 2 -> grant %0d", g);
      repeat (3) @(negedge ck);
      chk("sim_res", {bus.res0, bus.res1}, 32'hAAAA_5555);
      chk("sim_ovf", {30'd0, bus.ovf0, bus.ovf1}, 32'd1);
      chk("sim_ini_count", n_ini - i0, 2);

      // sol1 held high, sol0 re-requests after each fim0: strict alternation.
      bus.sol0 = 1'b1; bus.sol1 = 1'b1;
      for (int j = 0; j < 4; j++) begin
         wait_ini(ok);
         chk("alt_ini_seen", {31'd0, ok}, 32'd1);
         finish_op(1 + j, 16'h0100 + 16'(j), 1'b0, g, e);
         chk("alt_grant", g, j % 2);
         $display("[TB] alternation op %0d -> grant %0d", j, g);
         if (g == 0) bus.sol0 = 1'b0;
         @(negedge ck);
         bus.sol0 = 1'b1;
      end
      bus.sol0 = 1'b0; bus.sol1 = 1'b0;
      repeat (2) @(negedge ck);

      // Reset while in ESPERA aborts the operation without fim.
      set_ops(0, 64'h1357_2468_9ABC_DEF0);
      bus.sol0 = 1'b1;
      wait_ini(ok);
      repeat (2) @(negedge ck);
      f0 = n_fim0; f1 = n_fim1;
      rst = 1'b1; bus.sol0 = 1'b0;
      @(negedge ck);
      check_zero("abort");
      rst = 1'b0;
      bus.pronto_in = 1'b1; bus.res_in = 16'h7777;
      @(negedge ck);
      bus.pronto_in = 1'b0;
      repeat (3) @(negedge ck);
      chk("abort_fim_count", (n_fim0 - f0) + (n_fim1 - f1), 0);
      chk("abort_idle", {31'd0, bus.ocupado}, 32'd0);
      $display("[TB] reset-abort op -> fims %0d", (n_fim0 - f0) + (n_fim1 - f1));

      // Evaluator never answers.
      f0 = n_fim0;
      set_ops(0, 64'h0F0F_0F0F_0F0F_0F0F);
      bus.sol0 = 1'b1;
      wait_ini(ok);
      chk("wd_ini_seen", {31'd0, ok}, 32'd1);
`ifdef ESCALONADOR_TIMEOUT_EN
      ok = 1'b0; cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!ok) begin
            @(negedge ck);
            cnt++;
            ok = bus.fim0;
         end
      end
      bus.sol0 = 1'b0;
      chk("wd_fired", {31'd0, ok}, 32'd1);
      chk("wd_cycles", cnt, 9);
      chk("wd_res0", bus.res0, 16'h0000);
      chk("wd_ovf0", {31'd0, bus.ovf0}, 32'd1);
      chk("wd_erro", {31'd0, bus.erro_timeout}, 32'd1);
      @(negedge ck);
      chk("wd_erro_pulse", {31'd0, bus.erro_timeout}, 32'd0);
      $display("[TB] watchdog op -> fim after %0d cycles res0 %h ovf0 %b", cnt, bus.res0, bus.ovf0);
`else
      cnt = 0;
      repeat (20) begin
         @(negedge ck);
         cnt++;
      end
      chk("wait_ocupado", {31'd0, bus.ocupado}, 32'd1);
      chk("wait_no_fim", n_fim0 - f0, 0);
      chk("wait_erro", {31'd0, bus.erro_timeout}, 32'd0);
      $display("[TB] no-answer op -> still busy after %0d cycles", cnt);
      reset_dut();
      @(negedge ck);
      chk("wait_reset_idle", {31'd0, bus.ocupado}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/escalonador_polinomio.md
ESCALONADOR_POLINOMIO -- requirements
Module: escalonador_polinomio

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: maximum ESPERA cycles before the watchdog fires.
REQ-002 SHALL have port ck  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sol0, sol1  input  1 each  request level from requester 0/1.
REQ-005 SHALL have port x0, a0, b0, c0, x1, a1, b1, c1  input  16 each  polynomial operands per requester.
REQ-006 SHALL have port fim0, fim1  output  1 each  one-cycle completion pulse per requester.
REQ-007 SHALL have port res0, res1  output  16 each  last delivered result per requester.
REQ-008 SHALL have port ovf0, ovf1  output  1 each  last delivered overflow flag per requester.
REQ-009 SHALL have port ini_op  output  1  start pulse to the shared evaluator.
REQ-010 SHALL have port xo, ao, bo, co  output  16 each  latched operands driven to the evaluator.
REQ-011 SHALL have port res_in  input  16  evaluator result.
REQ-012 SHALL have port pronto_in  input  1  evaluator done.
REQ-013 SHALL have port ovf_in  input  1  evaluator overflow.
REQ-014 SHALL have port ocupado  output  1  high in every state except OCIOSO.
REQ-015 SHALL have port erro_timeout  output  1  one-cycle watchdog pulse.

Function
REQ-016 SHALL implement FSM OCIOSO -> DISPARA -> ESPERA -> ENTREGA -> OCIOSO; all outputs registered.
REQ-017 SHALL sample sol0/sol1 only in OCIOSO; on any request, grant one requester, latch its four operands into xo..co, and go to DISPARA.
REQ-018 SHALL arbitrate round-robin: with both requests, grant the requester other than the last one granted (pointer ultimo updated at grant).
REQ-019 SHALL hold ini_op=1 for exactly the single DISPARA cycle, then enter ESPERA.
REQ-020 SHALL hold xo..co constant from grant until leaving ENTREGA; requester operand changes after grant SHALL be ignored.
REQ-021 SHALL, in ESPERA, on pronto_in=1 capture res_in/ovf_in into the granted requester's res/ovf and go to ENTREGA.
REQ-022 SHALL ignore pronto_in, res_in, ovf_in in every state except ESPERA.
REQ-023 SHALL pulse fim of the granted requester for the single ENTREGA cycle; res/ovf of that requester update in that same cycle and hold until its next fim.
REQ-024 SHALL leave the other requester's res/ovf/fim untouched.
REQ-025 SHALL treat sol still high in OCIOSO as a new request; requesters deassert sol on the edge at which they sample fim=1.
REQ-026 SHALL have latency: sol sampled at edge t -> ini_op high in cycle t+1 -> fim high the cycle after pronto_in is sampled.

Reset
REQ-027 SHALL, when rst=1 at an edge in any state (including mid-operation), enter OCIOSO and clear fim0/1, res0/1, ovf0/1, ini_op, xo..co, ocupado, erro_timeout, and the watchdog counter to 0.
REQ-028 SHALL reset ultimo to requester 1 so requester 0 wins the first simultaneous arbitration.
REQ-029 SHALL NOT generate fim for an operation aborted by reset.

Configuration
REQ-030 SHALL, with ESCALONADOR_TIMEOUT_EN defined, count ESPERA cycles and, on reaching TIMEOUT without pronto_in, go to ENTREGA delivering res=0, ovf=1, and pulse erro_timeout with that fim.
REQ-031 SHALL, without ESCALONADOR_TIMEOUT_EN, have no counter, wait in ESPERA indefinitely, and tie erro_timeout to 0.
REQ-032 SHALL give pronto_in priority over the watchdog when both occur in the same cycle.

Verification
REQ-033 SHALL cover: rst, then sol0=1 with x0=0x0017, a0=0x0026, b0=0x814D, c0=0x9326 -> xo..co equal these, one ini_op pulse; model pronto after 10 cycles with res_in=0x1234 -> fim0 pulse, res0=0x1234, ovf0=0, fim1 never.
REQ-034 SHALL cover: sol0 and sol1 asserted on the same edge after reset -> requester 0 served first, then 1; exactly two ini_op pulses.
REQ-035 SHALL cover: sol1 held high while sol0 re-requests after each fim0 -> grants strictly alternate 0,1,0,1.
REQ-036 SHALL cover: pronto_in=1 with res_in=0xFFFF during OCIOSO and DISPARA -> no fim, res0/res1 unchanged.
REQ-037 SHALL cover: rst pulsed in ESPERA -> next cycle all outputs 0, ocupado=0, no fim for the aborted request.
REQ-038 SHALL cover: TIMEOUT=8, pronto_in never asserted -> with macro, fim, res=0, ovf=1, erro_timeout after 8 ESPERA cycles; without macro, ocupado stays 1.
